// File: rtl/fft_frame_sequencer.sv
// Sequences ADC sampling into an FFT frame buffer, then hands off to the FFT and SPI result link.
// A free-running sample-tick divider paces conversions; COMPUTE and TX are guarded by a done timeout.
//
// state     | meaning
// ----------+---------------------------------------------------------------
// IDLE      | waiting for enable; sample index parked at 0
// WAIT_TICK | loading frame, waiting for the next sample tick
// CONVERT   | ADC conversion in flight, waiting for adc_dv
// WRITE     | one-cycle write of the captured sample into the FFT buffer
// COMPUTE   | frame loaded, waiting for fft_done (timeout guarded)
// TX        | result transmission, waiting for spi_done (timeout guarded)
module fft_frame_sequencer #(
  parameter int SAMPLE_DIV   = 1000,
  parameter int N_SAMPLES    = 16,
  parameter int ADDR_W       = 4,
  parameter int DONE_TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  output logic              adc_sample,
  input  logic              adc_dv,
  input  logic [7:0]        adc_data,
  output logic              fft_load,
  output logic              fft_we,
  output logic [ADDR_W-1:0] fft_addr,
  output logic [15:0]       fft_data,
  input  logic              fft_done,
  output logic              spi_start,
  input  logic              spi_done,
  output logic [15:0]       frame_count,
  output logic              overrun,
  output logic              timeout_err
);

  localparam int TICK_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int TMO_W  = $clog2(DONE_TIMEOUT + 1);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_DIV - 1);
  localparam logic [ADDR_W-1:0] IDX_LAST  = ADDR_W'(N_SAMPLES - 1);
  localparam logic [TMO_W-1:0]  TMO_LOAD  = TMO_W'(DONE_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK,
    S_CONVERT,
    S_WRITE,
    S_COMPUTE,
    S_TX
  } state_t;

  state_t            state;
  logic [TICK_W-1:0] tick_cnt;
  logic [ADDR_W-1:0] idx;
  logic [TMO_W-1:0]  tmo_cnt;
  logic              tick;

  // The divider runs regardless of frame state so sample spacing stays uniform across frames.
  assign tick = enable && (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TICK_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      tmo_cnt     <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      fft_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state <= S_WAIT_TICK;
            idx   <= '0;
          end
        end
        S_WAIT_TICK: begin
          if (!enable) begin
            state <= S_IDLE;
            idx   <= '0;
          end else if (tick) begin
            state <= S_CONVERT;
          end
        end
        S_CONVERT: begin
          if (!enable) begin
            state <= S_IDLE;
            idx   <= '0;
          end else begin
            if (tick) overrun <= 1'b1;
            if (adc_dv) begin
              fft_data <= {8'h00, adc_data};
              state    <= S_WRITE;
            end
          end
        end
        S_WRITE: begin
          // A fully loaded frame always proceeds to the FFT, even if enable just dropped.
          if (idx == IDX_LAST) begin
            state   <= S_COMPUTE;
            tmo_cnt <= TMO_LOAD;
          end else if (enable) begin
            state <= S_WAIT_TICK;
            idx   <= idx + ADDR_W'(1);
          end else begin
            state <= S_IDLE;
            idx   <= '0;
          end
        end
        S_COMPUTE: begin
          if (fft_done) begin
            state   <= S_TX;
            tmo_cnt <= TMO_LOAD;
          end else if (tmo_cnt == '0) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            idx         <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        S_TX: begin
          if (spi_done) begin
            frame_count <= frame_count + 16'd1;
            idx         <= '0;
            state       <= enable ? S_WAIT_TICK : S_IDLE;
          end else if (tmo_cnt == '0) begin
            timeout_err <= 1'b1;
            state       <= S_IDLE;
            idx         <= '0;
          end else begin
            tmo_cnt <= tmo_cnt - TMO_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

  assign adc_sample = (state == S_WAIT_TICK) && tick;
  assign fft_we     = (state == S_WRITE);
  assign fft_load   = (state == S_WAIT_TICK) || (state == S_CONVERT) || (state == S_WRITE);
  assign fft_addr   = idx;
  assign spi_start  = (state == S_COMPUTE) && fft_done;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed-sequence bench for fft_frame_sequencer with a randomized ADC responder.
// Expected writes are derived from the conversions the ADC model actually delivered.
module tb_fft_frame_sequencer;

  localparam int DIV = 8;
  localparam int NS  = 16;
  localparam int TMO = 64;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        adc_sample;
  logic        adc_dv;
  logic [7:0]  adc_data;
  logic        fft_load;
  logic        fft_we;
  logic [3:0]  fft_addr;
  logic [15:0] fft_data;
  logic        fft_done;
  logic        spi_start;
  logic        spi_done;
  logic [15:0] frame_count;
  logic        overrun;
  logic        timeout_err;

  fft_frame_sequencer #(
    .SAMPLE_DIV  (DIV),
    .N_SAMPLES   (NS),
    .ADDR_W      (4),
    .DONE_TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .adc_sample (adc_sample),
    .adc_dv     (adc_dv),
    .adc_data   (adc_data),
    .fft_load   (fft_load),
    .fft_we     (fft_we),
    .fft_addr   (fft_addr),
    .fft_data   (fft_data),
    .fft_done   (fft_done),
    .spi_start  (spi_start),
    .spi_done   (spi_done),
    .frame_count(frame_count),
    .overrun    (overrun),
    .timeout_err(timeout_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_total = 0;
  int n_pass  = 0;

  // Observed write stream and delivered conversions
  int wr_addr_q[$];
  int wr_data_q[$];
  int wr_cyc_q[$];
  int dv_data_q[$];
  int dv_cyc_q[$];
  int smp_cnt = 0;

  // ADC model controls
  int adc_lat   = 3;
  bit lat_rand  = 1'b0;
  bit data_rand = 1'b0;
  int adc_idx   = 0;

  always @(negedge clk) begin
    if (fft_we) begin
      wr_addr_q.push_back(int'(fft_addr));
      wr_data_q.push_back(int'(fft_data));
      wr_cyc_q.push_back(cyc);
    end
    if (adc_sample) smp_cnt <= smp_cnt + 1;
  end

  initial begin : adc_model
    int lat;
    logic [7:0] d;
    adc_dv   = 1'b0;
    adc_data = 8'h00;
    forever begin
      @(negedge clk);
      if (adc_sample === 1'b1) begin
        lat = lat_rand ? int'($urandom_range(1, 6)) : adc_lat;
        d   = data_rand ? 8'($urandom) : 8'(adc_idx * 5);
        adc_idx++;
        repeat (lat) @(posedge clk);
        #1;
        adc_dv   = 1'b1;
        adc_data = d;
        dv_data_q.push_back(int'(d));
        dv_cyc_q.push_back(cyc);
        @(posedge clk);
        #1;
        adc_dv   = 1'b0;
        adc_data = 8'($urandom);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto_neg(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_writes(input int n, input int budget);
    int t = 0;
    while (wr_addr_q.size() < n && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("write_count", wr_addr_q.size(), n);
  endtask

  task automatic clear_q();
    wr_addr_q.delete();
    wr_data_q.delete();
    wr_cyc_q.delete();
    dv_data_q.delete();
    dv_cyc_q.delete();
  endtask

  // Every write k must carry address k and the k-th delivered conversion, one cycle after its adc_dv.
  task automatic check_frame(input string tag);
    for (int k = 0; k < NS; k++) begin
      if (k < wr_addr_q.size() && k < dv_data_q.size()) begin
        check({tag, "_addr"}, wr_addr_q[k], k);
        check({tag, "_data"}, wr_data_q[k], dv_data_q[k]);
        check({tag, "_lat"},  wr_cyc_q[k],  dv_cyc_q[k] + 1);
      end
    end
  endtask

  initial begin : main
    int w;
    int c;
    int s0;
    int t;
    rst      = 1'b1;
    enable   = 1'b0;
    fft_done = 1'b0;
    spi_done = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_load",    32'(fft_load), 0);
    check("rst_we",      32'(fft_we), 0);
    check("rst_sample",  32'(adc_sample), 0);
    check("rst_spi",     32'(spi_start), 0);
    check("rst_data",    32'(fft_data), 0);
    check("rst_addr",    32'(fft_addr), 0);
    check("rst_fc",      32'(frame_count), 0);
    check("rst_ovr",     32'(overrun), 0);
    check("rst_tmo",     32'(timeout_err), 0);
    step();
    rst = 1'b0;

    // Frame 1: fixed latency 3, data = index*5
    clear_q();
    s0 = smp_cnt;
    step();
    enable = 1'b1;
    wait_writes(NS, 400);
    check_frame("f1");
    for (int k = 0; k < NS && k < wr_data_q.size(); k++) begin
      check("f1_val", wr_data_q[k], k * 5);
      if (k > 0) check("f1_gap", wr_cyc_q[k] - wr_cyc_q[k-1], DIV);
    end
    w = (wr_cyc_q.size() >= NS) ? wr_cyc_q[NS-1] : cyc;
    goto_neg(w + 1);
    check("f1_load_fall", 32'(fft_load), 0);
    check("f1_we_idle",   32'(fft_we), 0);
    check("f1_samples",   smp_cnt - s0, NS);
    check("f1_ovr",       32'(overrun), 0);
    step();
    fft_done = 1'b1;
    @(negedge clk);
    check("f1_spi_start", 32'(spi_start), 1);
    step();
    fft_done = 1'b0;
    step();
    clear_q();
    data_rand = 1'b1;
    lat_rand  = 1'b1;
    spi_done  = 1'b1;
    @(negedge clk);
    check("f1_fc_pre", 32'(frame_count), 0);
    step();
    spi_done = 1'b0;
    @(negedge clk);
    check("f1_fc", 32'(frame_count), 1);
    check("f1_next", 32'(fft_load), 1);

    // Frame 2: random data/latency, stray done pulses ignored, enable dropped during COMPUTE
    wait_writes(4, 200);
    step();
    fft_done = 1'b1;
    spi_done = 1'b1;
    @(negedge clk);
    check("stray_spi_start", 32'(spi_start), 0);
    step();
    fft_done = 1'b0;
    spi_done = 1'b0;
    wait_writes(NS, 400);
    check_frame("f2");
    w = (wr_cyc_q.size() >= NS) ? wr_cyc_q[NS-1] : cyc;
    goto_neg(w);
    step();
    enable   = 1'b0;
    fft_done = 1'b1;
    @(negedge clk);
    check("f2_spi_start", 32'(spi_start), 1);
    step();
    fft_done = 1'b0;
    @(negedge clk);
    check("f2_fc_pre", 32'(frame_count), 1);
    step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    @(negedge clk);
    check("f2_fc", 32'(frame_count), 2);
    check("f2_idle", 32'(fft_load), 0);
    repeat (10) @(negedge clk);
    check("f2_stay_idle", 32'(fft_load), 0);

    // Frame 3: conversion withheld past the next tick
    clear_q();
    lat_rand = 1'b0;
    adc_lat  = 10;
    s0 = smp_cnt;
    step();
    enable = 1'b1;
    wait_writes(1, 100);
    check("ovr_set", 32'(overrun), 1);
    check("ovr_one_sample", smp_cnt - s0, 1);
    adc_lat = 3;
    wait_writes(NS, 400);
    check_frame("f3");
    check("ovr_sticky", 32'(overrun), 1);

    // Reset while in COMPUTE
    w = (wr_cyc_q.size() >= NS) ? wr_cyc_q[NS-1] : cyc;
    goto_neg(w + 5);
    step();
    rst    = 1'b1;
    enable = 1'b0;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ovr",  32'(overrun), 0);
    check("mid_rst_fc",   32'(frame_count), 0);
    check("mid_rst_load", 32'(fft_load), 0);
    check("mid_rst_we",   32'(fft_we), 0);
    check("mid_rst_data", 32'(fft_data), 0);
    check("mid_rst_tmo",  32'(timeout_err), 0);
    check("mid_rst_spi",  32'(spi_start), 0);

    // Frame 4: fft_done never arrives
    clear_q();
    lat_rand = 1'b1;
    step();
    enable = 1'b1;
    wait_writes(NS, 400);
    w = (wr_cyc_q.size() >= NS) ? wr_cyc_q[NS-1] : cyc;
    goto_neg(w + TMO);
    check("tmo_early", 32'(timeout_err), 0);
    goto_neg(w + TMO + 1);
    check("tmo_set",  32'(timeout_err), 1);
    check("tmo_idle", 32'(fft_load), 0);
    check("tmo_fc",   32'(frame_count), 0);
    step();
    enable = 1'b0;
    step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    @(negedge clk);
    check("tmo_fc_hold", 32'(frame_count), 0);
    check("tmo_sticky",  32'(timeout_err), 1);

    // Frame 5: abort mid-conversion after five writes
    clear_q();
    lat_rand = 1'b0;
    adc_lat  = 3;
    step();
    enable = 1'b1;
    wait_writes(5, 200);
    t = 0;
    while (adc_sample !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    check("abort_sample_seen", 32'(adc_sample), 1);
    c = cyc;
    step();
    enable = 1'b0;
    goto_neg(c + 2);
    check("abort_load", 32'(fft_load), 0);
    goto_neg(c + 22);
    check("abort_no_we", wr_addr_q.size(), 5);

    // Counter wrap, then a full frame restarting at address 0
    force dut.frame_count = 16'hFFFF;
    step();
    release dut.frame_count;
    @(negedge clk);
    check("wrap_preload", 32'(frame_count), 32'h0000FFFF);
    clear_q();
    lat_rand = 1'b1;
    step();
    enable = 1'b1;
    wait_writes(NS, 400);
    check_frame("f6");
    w = (wr_cyc_q.size() >= NS) ? wr_cyc_q[NS-1] : cyc;
    goto_neg(w);
    step();
    fft_done = 1'b1;
    step();
    fft_done = 1'b0;
    step();
    spi_done = 1'b1;
    step();
    spi_done = 1'b0;
    enable   = 1'b0;
    @(negedge clk);
    check("wrap_fc",  32'(frame_count), 0);
    check("wrap_tmo", 32'(timeout_err), 1);
    check("wrap_ovr", 32'(overrun), 0);

    repeat (5) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fft_frame_sequencer.md
FFT_FRAME_SEQUENCER -- requirements
Module: fft_frame_sequencer

Interface
REQ-001 Parameter SAMPLE_DIV, default 1000, clk cycles per ADC sample tick (16 kHz at 16 MHz); legal range 4..65535.
REQ-002 Parameter N_SAMPLES, default 16, samples per FFT frame; power of two.
REQ-003 Parameter ADDR_W, default 4, width of sample address (log2 N_SAMPLES).
REQ-004 Parameter DONE_TIMEOUT, default 4096, max clk cycles allowed in COMPUTE or TX.
REQ-005 clk  in  1  system clock; one clock domain; all logic on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 enable  in  1  level; 1 = run frames continuously.
REQ-008 adc_sample  out  1  one-cycle pulse starting one ADC conversion.
REQ-009 adc_dv  in  1  one-cycle pulse; adc_data valid.
REQ-010 adc_data  in  8  ADC conversion result.
REQ-011 fft_load  out  1  level, high while a frame is being loaded into the FFT.
REQ-012 fft_we  out  1  one-cycle write strobe for fft_addr/fft_data.
REQ-013 fft_addr  out  ADDR_W  sample index being written.
REQ-014 fft_data  out  16  sample word, {8'h00, adc_data}.
REQ-015 fft_done  in  1  one-cycle pulse, FFT computation complete.
REQ-016 spi_start  out  1  one-cycle pulse starting result transmission.
REQ-017 spi_done  in  1  one-cycle pulse, transmission complete.
REQ-018 frame_count  out  16  completed frames, wraps 16'hFFFF -> 0.
REQ-019 overrun  out  1  sticky; a sample tick occurred with a conversion still pending.
REQ-020 timeout_err  out  1  sticky; fft_done or spi_done not received within DONE_TIMEOUT.

Function
REQ-021 States: IDLE, WAIT_TICK, CONVERT, WRITE, COMPUTE, TX.
REQ-022 Tick counter counts 0..SAMPLE_DIV-1 while enable=1, wraps; tick asserted for the cycle the count equals SAMPLE_DIV-1; counter held at 0 while enable=0.
REQ-023 IDLE: enable=1 -> WAIT_TICK, sample index cleared to 0.
REQ-024 WAIT_TICK: on tick, adc_sample=1 that cycle, next state CONVERT.
REQ-025 CONVERT: on adc_dv, fft_data <= {8'h00, adc_data}, next state WRITE.
REQ-026 CONVERT: tick without adc_dv in the same cycle sets overrun; state unchanged; no adc_sample issued.
REQ-027 CONVERT: tick and adc_dv in the same cycle: data accepted per REQ-025 and overrun set.
REQ-028 WRITE: fft_we=1 for exactly one cycle with fft_addr = sample index; index = N_SAMPLES-1 -> COMPUTE, otherwise index+1 and WAIT_TICK.
REQ-029 fft_load = 1 in WAIT_TICK, CONVERT and WRITE; 0 in all other states; it falls on the cycle after the last fft_we.
REQ-030 COMPUTE: fft_done -> spi_start=1 that cycle, next state TX; DONE_TIMEOUT cycles without fft_done -> timeout_err set, IDLE.
REQ-031 TX: spi_done -> frame_count+1, then WAIT_TICK with index 0 if enable=1, else IDLE; DONE_TIMEOUT cycles without spi_done -> timeout_err set, IDLE, frame_count unchanged.
REQ-032 Timeout counter cleared on entry to COMPUTE and to TX.
REQ-033 enable=0 in WAIT_TICK or CONVERT aborts the frame: next state IDLE, index 0, no fft_we; a late adc_dv is ignored.
REQ-034 enable=0 in WRITE, COMPUTE or TX does not abort; the current write/frame completes, then IDLE.
REQ-035 fft_done, spi_done and adc_dv outside their owning state are ignored.
REQ-036 Latency: tick -> adc_sample same cycle; adc_dv -> fft_we next cycle; fft_done -> spi_start same cycle.

Reset
REQ-037 rst=1 at a clock edge: state IDLE; tick counter, index, timeout counter, frame_count, overrun, timeout_err and fft_data all 0; all strobes and fft_load 0.
REQ-038 rst takes priority over every other input, including mid-frame; sticky flags clear only on rst.

Verification (SAMPLE_DIV=8, N_SAMPLES=16, DONE_TIMEOUT=64)
REQ-039 Full frame: enable=1; ADC model answers adc_dv 3 cycles after adc_sample with data = index*5 -> 16 fft_we with addr 0..15 and data 16'h0000..16'h004B, 8 cycles apart; fft_done pulse -> spi_start; spi_done -> frame_count=1, next frame starts.
REQ-040 Overrun: ADC model withholds adc_dv for 10 cycles -> overrun=1 and no second adc_sample; subsequent dv accepted and the frame continues.
REQ-041 Timeout: fft_done never pulsed -> timeout_err=1 exactly 64 cycles after COMPUTE entry, state IDLE, frame_count unchanged.
REQ-042 Abort: enable dropped after 5 writes -> fft_load=0 within one cycle, no further fft_we; enable re-raised -> first write addr 0.
REQ-043 Reset mid-COMPUTE with overrun=1 -> all outputs 0 on next cycle, frame_count=0.
REQ-044 Wrap: preload 65535 completed frames (or force counter) -> next spi_done gives frame_count=0.
